// File: rtl/fifo_sync_n.sv
// rtl/fifo_sync_n.sv - parametrised single-clock FIFO with standard or first-word-fall-through read
module fifo_sync_n #(
    parameter int WIDTH     = 48,
    parameter int ADDR_W    = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (1 << ADDR_W) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AEMPTY_TH[ADDR_W:0];

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              wr_acc;
    logic              rd_acc;
    logic              ram_rd;
    logic              valid_next;
    logic              prime;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   ram_cnt;

    // Accept/reject decisions, next occupancy, and when the RAM head is consumed.
    // In FWFT mode the staged word is part of count, so the RAM holds count - valid.
    // An empty output stage waits one extra cycle (prime) after a word lands in RAM
    // before fetching it; a popping stage refills from RAM on the same edge.
    always_comb begin
        wr_acc     = wr_en && !full && !rst;
        rd_acc     = rd_en && !empty && !rst;
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
        ram_cnt    = (FWFT != 0) ? (count - {{ADDR_W{1'b0}}, valid}) : count;
        ram_rd     = 1'b0;
        valid_next = 1'b0;
        if (FWFT == 0) begin
            ram_rd     = rd_acc;
            valid_next = rd_acc;
        end else begin
            if (valid) begin
                ram_rd = rd_acc && (ram_cnt != '0);
            end else begin
                ram_rd = prime && (ram_cnt != '0);
            end
            if (ram_rd) begin
                valid_next = 1'b1;
            end else if (rd_acc) begin
                valid_next = 1'b0;
            end else begin
                valid_next = valid;
            end
        end
    end

    // Storage array; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, output register, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            dout         <= '0;
            valid        <= 1'b0;
            prime        <= 1'b0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            valid        <= valid_next;
            prime        <= (FWFT != 0) && !valid && (ram_cnt != '0) && !ram_rd;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (FWFT != 0) ? !valid_next : (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_n.sv
// tb/tb_fifo_sync_n.sv - scoreboard bench for fifo_sync_n in standard and FWFT modes
module tb_fifo_sync_n;

    localparam int W  = 48;
    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst;

    logic [W-1:0]  din;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  s_dout;
    logic          s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [AW:0]   s_count;

    logic [W-1:0]  f_din;
    logic          f_wr;
    logic          f_rd;
    logic [W-1:0]  f_dout;
    logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   f_count;

    int            checks = 0;
    int            errors = 0;

    logic [W-1:0]  sq[$];
    logic [W-1:0]  fq[$];
    int            mc = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    fifo_sync_n #(.WIDTH(W), .ADDR_W(AW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_n #(.WIDTH(W), .ADDR_W(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
        .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        bit r, wa, ra;
        logic [W-1:0] exp;
        r  = rst;
        wa = !r && wr_en && (mc < D);
        ra = !r && rd_en && (mc > 0);
        if (!r && wr_en && mc == D) m_ovf = 1'b1;
        if (!r && rd_en && mc == 0) m_unf = 1'b1;
        if (wa) sq.push_back(din);
        @(posedge clk);
        #1;
        if (r) begin
            mc = 0;
            sq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            mc = mc + int'(wa) - int'(ra);
        end
        check("s_count", 64'(s_count), 64'(mc));
        check("s_full", 64'(s_full), 64'(mc == D));
        check("s_empty", 64'(s_empty), 64'(mc == 0));
        check("s_almost_full", 64'(s_af), 64'(mc >= D - 2));
        check("s_almost_empty", 64'(s_ae), 64'(mc <= 2));
        check("s_overflow", 64'(s_ovf), 64'(m_ovf));
        check("s_underflow", 64'(s_unf), 64'(m_unf));
        check("s_valid", 64'(s_valid), 64'(ra));
        if (ra) begin
            exp = sq.pop_front();
            check("s_dout", 64'(s_dout), 64'(exp));
        end
        if (r) check("s_dout_rst", 64'(s_dout), 64'd0);
    endtask

    task automatic ftick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] dc;
        logic [W-1:0] e;
        int cyc;
        rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        f_din = '0; f_wr = 1'b0; f_rd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("f_reset_empty", 64'(f_empty), 64'd1);
        check("f_reset_valid", 64'(f_valid), 64'd0);
        check("f_reset_ae", 64'(f_ae), 64'd1);

        // fill 16, then a rejected 17th write
        wr_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            din = W'(i);
            tick();
        end
        wr_en = 1'b0;
        check("fill_count", 64'(s_count), 64'd16);
        check("fill_ovf", 64'(s_ovf), 64'd1);

        // drain 16, then a rejected 17th read
        rd_en = 1'b1;
        repeat (17) tick();
        rd_en = 1'b0;
        tick();
        check("drain_unf", 64'(s_unf), 64'd1);

        // steady state at count 8 with pointer wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dc = 48'h100;
        wr_en = 1'b1;
        repeat (8) begin din = dc; dc = dc + 1'b1; tick(); end
        rd_en = 1'b1;
        repeat (100) begin din = dc; dc = dc + 1'b1; tick(); end
        check("hold_count", 64'(s_count), 64'd8);
        rd_en = 1'b0;
        repeat (8) begin din = dc; dc = dc + 1'b1; tick(); end
        check("refull", 64'(s_full), 64'd1);

        // full with simultaneous write and read
        rd_en = 1'b1;
        din = dc;
        tick();
        check("fullwr_count", 64'(s_count), 64'd15);
        check("fullwr_ovf", 64'(s_ovf), 64'd1);
        wr_en = 1'b0;
        repeat (6) tick();
        rd_en = 1'b0;
        check("pre_rst_count", 64'(s_count), 64'd9);

        // reset mid-operation with requests asserted
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check("rst_ovf", 64'(s_ovf), 64'd0);
        din = 48'hDEAD_BEEF_0001;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("sb_left", 64'(sq.size()), 64'd0);

        // FWFT single word: visible two edges after the write edge
        f_din = 48'hABCDEF012345;
        f_wr = 1'b1;
        ftick();
        f_wr = 1'b0;
        check("f1_valid_e1", 64'(f_valid), 64'd0);
        check("f1_count_e1", 64'(f_count), 64'd1);
        ftick();
        check("f1_valid_e2", 64'(f_valid), 64'd0);
        ftick();
        check("f1_valid_e3", 64'(f_valid), 64'd1);
        check("f1_dout", 64'(f_dout), 64'h0000ABCDEF012345);
        check("f1_empty", 64'(f_empty), 64'd0);
        f_rd = 1'b1;
        ftick();
        f_rd = 1'b0;
        check("f1_pop_valid", 64'(f_valid), 64'd0);
        check("f1_pop_empty", 64'(f_empty), 64'd1);
        check("f1_pop_count", 64'(f_count), 64'd0);

        // FWFT fill to capacity, overflow, then drain without bubbles
        f_wr = 1'b1;
        for (int i = 0; i < D; i++) begin
            f_din = 48'h5000 + W'(i);
            fq.push_back(f_din);
            ftick();
            check("f_fill_count", 64'(f_count), 64'(i + 1));
        end
        check("f_full", 64'(f_full), 64'd1);
        check("f_af", 64'(f_af), 64'd1);
        f_din = 48'h5FFF;
        ftick();
        f_wr = 1'b0;
        check("f_ovf", 64'(f_ovf), 64'd1);
        check("f_ovf_count", 64'(f_count), 64'd16);
        f_rd = 1'b1;
        cyc = 0;
        for (int c = 0; c < 40 && fq.size() > 0; c++) begin
            if (f_valid) begin
                e = fq.pop_front();
                check("f_dout", 64'(f_dout), 64'(e));
            end
            ftick();
            cyc++;
        end
        f_rd = 1'b0;
        check("f_drain_left", 64'(fq.size()), 64'd0);
        check("f_no_bubble", 64'(cyc), 64'd16);
        check("f_end_empty", 64'(f_empty), 64'd1);
        check("f_end_count", 64'(f_count), 64'd0);
        check("f_end_valid", 64'(f_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
